lsu_rmw: RTL and testbench

- Load/store unit between the CPU datapath and the byte-addressed, big-endian data memory, which has a 32-bit port and combinational read.
- Accepts byte, half and word loads and stores from the core.
- Word-aligns every memory access and extracts or sign-extends load data.
- Performs sub-word stores as read-modify-write, because the memory only writes whole 4-byte groups.
- Stalls the core through a ready/valid handshake while an access is in flight.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_lane.sv | 44 ++++
 rtl/lsu_rmw.sv | 140 ++++++++++++++
 tb/tb_lsu_rmw.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
// Size codes, FSM states and the default data memory size.
package lsu_pkg;

  localparam int MEM_BYTES_DEF = 16384;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } state_e;

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: big-endian lane extract/extend and sub-word merge.
// Purely combinational; half accesses pick their lane from off[1].
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result,
  output logic [31:0] merged
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  b;
  logic [15:0] h;

  // offset 0 is the most significant lane
  assign bsh = {~off, 3'b000};
  assign hsh = {~off[1], 4'b0000};
  assign b   = word[bsh +: 8];
  assign h   = word[hsh +: 16];

  always_comb begin
    result = word;
    merged = wdata;
    unique case (1'b1)
      size == SZ_BYTE: begin
        result = {{24{~uns & b[7]}}, b};
        merged = word;
        merged[bsh +: 8] = wdata[7:0];
      end
      size == SZ_HALF: begin
        result = {{16{~uns & h[15]}}, h};
        merged = word;
        merged[hsh +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit with read-modify-write for sub-word stores.
// Define LSU_ALIGN_CHECK_EN to flag misaligned half/word accesses.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_rvalid,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wvalid,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata
);

  state_e state, nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              we_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [31:0]       wbuf_q;

  logic [ADDR_W-1:0] req_wa;
  logic [ADDR_W:0]   last_byte;
  logic              range_err;
  logic              align_err;
  logic              req_err;
  logic              accept;
  logic [ADDR_W-1:0] wa;
  logic [31:0]       lane_result;
  logic [31:0]       lane_merged;

  assign req_wa    = {req_addr[ADDR_W-1:2], 2'b00};
  assign last_byte = {1'b0, req_wa} + (ADDR_W+1)'(3);
  assign range_err = last_byte >= (ADDR_W+1)'(MEM_BYTES);

`ifdef LSU_ALIGN_CHECK_EN
  assign align_err = (req_size == SZ_HALF && req_addr[0]) ||
                     (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
`else
  assign align_err = 1'b0;
`endif

  assign req_err = (req_size == 2'd3) || range_err || align_err;
  assign accept  = req_valid && req_ready;
  assign wa      = {addr_q[ADDR_W-1:2], 2'b00};

  lsu_lane u_lane (
    .word   (mem_rdata),
    .wdata  (wbuf_q),
    .off    (addr_q[1:0]),
    .size   (size_q),
    .uns    (uns_q),
    .result (lane_result),
    .merged (lane_merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt        = state;
    req_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_wvalid = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                          nxt = ST_RESP;
          else if (req_we && req_size == SZ_WORD) nxt = ST_WR;
          else                                  nxt = ST_RD;
        end
      end
      ST_RD: begin
        mem_rvalid = 1'b1;
        nxt = we_q ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        mem_wvalid = 1'b1;
        nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // wbuf_q holds store data until RD replaces it with the merged word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wbuf_q  <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      we_q    <= req_we;
      err_q   <= req_err;
      rdata_q <= '0;
      wbuf_q  <= req_wdata;
    end else if (state == ST_RD) begin
      if (we_q) wbuf_q  <= lane_merged;
      else      rdata_q <= lane_result;
    end
  end

  assign mem_raddr  = mem_rvalid ? wa : '0;
  assign mem_waddr  = mem_wvalid ? wa : '0;
  assign mem_wdata  = mem_wvalid ? wbuf_q : '0;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid ? err_q : 1'b0;

endmodule

// File: tb/tb_lsu_rmw.sv
// tb_lsu_rmw: random and directed checks of lsu_rmw against a
// byte-array memory model.
module tb_lsu_rmw;

  localparam int MB = 16384;
`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rvalid;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_wvalid;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;

  lsu_rmw #(.MEM_BYTES(MB), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_rvalid   (mem_rvalid),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata),
    .mem_wvalid   (mem_wvalid),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata)
  );

  always #5 clk = ~clk;

  // memory seen by the DUT, and the reference byte image
  logic [31:0] dmem [MB/4];
  logic [7:0]  ref_mem [MB];

  assign mem_rdata = dmem[mem_raddr[13:2]];

  always @(posedge clk)
    if (mem_wvalid) dmem[mem_waddr[13:2]] = mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // expectation of the transaction in flight
  logic        pending = 1'b0;
  logic        exp_we, exp_err;
  logic [31:0] exp_rdata, exp_wa, exp_wword;
  int          exp_lat, exp_nrd, exp_nwr, acc_cyc;
  int          n_rd, n_wr;
  logic [31:0] last_rdata, last_waddr, last_wdata;
  logic        last_err;
  int          last_lat, last_nrd, last_nwr;

  task automatic model(input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata,
                       output logic err, output logic [31:0] rdata,
                       output int lat, output int nrd, output int nwr,
                       output logic [31:0] wa, output logic [31:0] wword);
    int n, a, w;
    logic [7:0] bb [4];
    logic [31:0] val;
    wa = addr & ~32'h3;
    err = (size == 2'd3) || ({1'b0, wa} + 33'd3 >= 33'(MB));
    if (ALIGN && ((size == 2'd1 && addr[0]) ||
                  (size == 2'd2 && addr[1:0] != 2'b00)))
      err = 1'b1;
    rdata = '0; wword = '0; nrd = 0; nwr = 0; lat = 1;
    if (err) return;
    n = 1 << size;
    w = int'(wa);
    if (size == 2'd0)      a = w + int'(addr[1:0]);
    else if (size == 2'd1) a = w + (addr[1] ? 2 : 0);
    else                   a = w;
    if (!we) begin
      val = '0;
      for (int i = 0; i < n; i++) val = (val << 8) | 32'(ref_mem[a + i]);
      if (!uns && n == 1 && val[7])  val = val | 32'hFFFF_FF00;
      if (!uns && n == 2 && val[15]) val = val | 32'hFFFF_0000;
      rdata = val; lat = 2; nrd = 1;
    end else begin
      for (int i = 0; i < 4; i++) bb[i] = ref_mem[w + i];
      for (int i = 0; i < n; i++) bb[a - w + i] = 8'(wdata >> (8 * (n - 1 - i)));
      wword = {bb[0], bb[1], bb[2], bb[3]};
      nwr = 1;
      nrd = (n < 4) ? 1 : 0;
      lat = (n < 4) ? 3 : 2;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (!pending) begin
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_quiet", {29'd0, mem_rvalid, mem_wvalid, resp_valid}, 32'd0);
      end else begin
        chk("busy_ready", 32'(req_ready), 32'd0);
        if (mem_rvalid) begin
          n_rd++;
          chk("raddr", mem_raddr, exp_wa);
        end
        if (mem_wvalid) begin
          n_wr++;
          last_waddr = mem_waddr;
          last_wdata = mem_wdata;
          chk("waddr", mem_waddr, exp_wa);
          chk("wdata", mem_wdata, exp_wword);
        end
        if (resp_valid) begin
          last_lat = cyc - acc_cyc;
          last_rdata = resp_rdata;
          last_err = resp_err;
          last_nrd = n_rd;
          last_nwr = n_wr;
          chk("latency", 32'(last_lat), 32'(exp_lat));
          chk("resp_err", 32'(resp_err), 32'(exp_err));
          chk("resp_rdata", resp_rdata, exp_rdata);
          chk("n_reads", 32'(n_rd), 32'(exp_nrd));
          chk("n_writes", 32'(n_wr), 32'(exp_nwr));
          if (exp_we && !exp_err)
            for (int i = 0; i < 4; i++)
              ref_mem[int'(exp_wa) + i] = exp_wword[8 * (3 - i) +: 8];
          pending = 1'b0;
        end
      end
    end
  end

  task automatic garble();
    req_valid = 1'($urandom_range(0, 1));
    req_we = 1'($urandom_range(0, 1));
    req_size = 2'($urandom_range(0, 3));
    req_unsigned = 1'($urandom_range(0, 1));
    req_addr = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata);
    int n, a_cyc, lat, nrd, nwr;
    logic e;
    logic [31:0] rd, wa, ww;
    @(negedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = size;
    req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    model(we, size, uns, addr, wdata, e, rd, lat, nrd, nwr, wa, ww);
    a_cyc = cyc;
    @(posedge clk);
    exp_we = we; exp_err = e; exp_rdata = rd; exp_lat = lat;
    exp_nrd = nrd; exp_nwr = nwr; exp_wa = wa; exp_wword = ww;
    acc_cyc = a_cyc; n_rd = 0; n_wr = 0;
    last_rdata = '0; last_err = 1'b0; last_lat = 0;
    last_waddr = '0; last_wdata = '0;
    pending = 1'b1;
    #1 garble();
    n = 0;
    while (pending && n < 12) begin
      @(negedge clk); #1;
      if (pending) garble();
      n++;
    end
    req_valid = 1'b0;
    if (pending) begin
      chk("resp_timeout", 32'd0, 32'd1);
      pending = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] r, a;
    logic [1:0]  sz;
    int bad;
    for (int w = 0; w < MB / 4; w++) begin
      r = $urandom;
      dmem[w] = r;
      for (int i = 0; i < 4; i++) ref_mem[4 * w + i] = r[8 * (3 - i) +: 8];
    end
    dmem[4] = 32'h8899_AABB;
    ref_mem[16] = 8'h88; ref_mem[17] = 8'h99;
    ref_mem[18] = 8'hAA; ref_mem[19] = 8'hBB;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_strobes", {30'd0, mem_rvalid, mem_wvalid}, 32'd0);
    chk("rst_resp", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata | {31'd0, resp_err}, 32'd0);
    chk("rst_addr", mem_raddr | mem_waddr | mem_wdata, 32'd0);
    #1 rst = 1'b1;

    do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
    chk("tp1_rdata", last_rdata, 32'hFFFF_FF88);
    chk("tp1_lat", 32'(last_lat), 32'd2);
    chk("tp1_rd", 32'(last_nrd), 32'd1);
    chk("tp1_wr", 32'(last_nwr), 32'd0);

    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    chk("tp2_ubyte", last_rdata, 32'h0000_00BB);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    chk("tp2_shalf", last_rdata, 32'hFFFF_AABB);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("tp2_word", last_rdata, 32'h8899_AABB);

    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_0055);
    chk("tp3_wdata", last_wdata, 32'h8855_AABB);
    chk("tp3_waddr", last_waddr, 32'h10);
    chk("tp3_lat", 32'(last_lat), 32'd3);
    chk("tp3_err", 32'(last_err), 32'd0);
    chk("tp3_mem", dmem[4], 32'h8855_AABB);

    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF);
    chk("tp4_rd", 32'(last_nrd), 32'd0);
    chk("tp4_wr", 32'(last_nwr), 32'd1);
    chk("tp4_lat", 32'(last_lat), 32'd2);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    chk("tp4_load", last_rdata, 32'hDEAD_BEEF);

    do_req(1'b0, 2'd2, 1'b0, 32'h22, 32'h0);
    chk("tp5_mis_err", 32'(last_err), 32'(ALIGN));
    chk("tp5_mis_data", last_rdata, ALIGN ? 32'h0 : 32'hDEAD_BEEF);
    chk("tp5_mis_lat", 32'(last_lat), ALIGN ? 32'd1 : 32'd2);
    do_req(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0);
    chk("tp5_oor_err", 32'(last_err), 32'd1);
    chk("tp5_oor_lat", 32'(last_lat), 32'd1);
    do_req(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h1234_5678);
    chk("tp5_oor_st", {30'd0, last_err, 1'(last_nwr)}, 32'd2);
    do_req(1'b0, 2'd2, 1'b0, 32'h3FFC, 32'h0);
    chk("tp5_top_ok", 32'(last_err), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h3FFE, 32'h0);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    chk("tp5_size3", 32'(last_err), 32'd1);

    // reset while the read half of a byte store is in flight
    @(negedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0;
    req_addr = 32'h10; req_wdata = 32'h77;
    @(posedge clk); #2;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_strobes", {30'd0, mem_rvalid, mem_wvalid}, 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk); #1 rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_mem", dmem[4], 32'h8855_AABB);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 255));
      else a = 32'($urandom_range(0, MB - 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    bad = 0;
    for (int w = 0; w < MB / 4; w++)
      if (dmem[w] !== {ref_mem[4*w], ref_mem[4*w+1], ref_mem[4*w+2], ref_mem[4*w+3]})
        bad++;
    chk("final_mem", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
